// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with a
// leading-zero blank mask for seven-segment digit drivers.
module bin2bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          bin,
  output logic                  out_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  generate
    if (pow10(DIGITS) <= ((64'd1 << W) - 64'd1)) begin : g_too_few_digits
      $error("bin2bcd_seq: DIGITS=%0d cannot hold a %0d-bit value", DIGITS, W);
    end
  endgenerate

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_shift = 2'd1,
    s_done  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     sreg_reg;
  logic [CW-1:0]     cnt_reg;
  logic [BW-1:0]     bcd_reg;
  logic [DIGITS-1:0] blank_reg;

  logic [SW-1:0]     adj;
  logic [SW-1:0]     shift_next;
  logic [BW-1:0]     bcd_next;
  logic [DIGITS-1:0] dig_zero;
  logic [DIGITS-1:0] blank_next;
  logic              accept;
  logic              last_bit;

  // Add-3 correction on every BCD nibble before the shift; binary part passes through.
  assign adj[W-1:0] = sreg_reg[W-1:0];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sreg_reg[W + 4*gi +: 4];
      assign adj[W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign shift_next = adj << 1;
  assign bcd_next   = shift_next[SW-1:W];

  // A digit is blanked when it and every more significant digit are zero; digit 0 always shows.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      assign dig_zero[gi] = (bcd_next[4*gi +: 4] == 4'd0);
      if (gi == 0) begin : g_lsd
        assign blank_next[gi] = 1'b0;
      end else begin : g_upper
        assign blank_next[gi] = &dig_zero[DIGITS-1:gi];
      end
    end
  endgenerate

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_reg == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= s_idle;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      s_idle:  if (accept) state_next = s_shift;
      s_shift: if (last_bit) state_next = s_done;
      s_done:  state_next = accept ? s_shift : s_idle;
      default: state_next = s_idle;
    endcase
  end

  always_comb begin
    in_ready  = ((state_reg == s_idle) || (state_reg == s_done)) && !reset;
    busy      = (state_reg == s_shift);
    out_valid = (state_reg == s_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      bcd_reg   <= '0;
      blank_reg <= '0;
    end else if (accept) begin
      sreg_reg <= {{BW{1'b0}}, bin};
      cnt_reg  <= CW'(W);
    end else if (state_reg == s_shift) begin
      sreg_reg <= shift_next;
      cnt_reg  <= cnt_reg - CW'(1);
      if (last_bit) begin
        bcd_reg   <= bcd_next;
        blank_reg <= blank_next;
      end
    end
  end

  assign bcd   = bcd_reg;
  assign blank = blank_reg;

endmodule
